// File: rtl/vram_if.sv
// -----------------------------------------------------------------------------
// vram_if -- CPU-side VRAM access bus (ISA-style) between a host and the
// vram_arbiter.
//
//   cpu_req    host -> arb  level request, held until cpu_ack
//   cpu_we     host -> arb  1 = write, 0 = read (stable while cpu_req high)
//   cpu_addr   host -> arb  14-bit VRAM byte address
//   cpu_wdata  host -> arb  write data
//   cpu_ack    arb -> host  one-clk completion pulse
//   cpu_rdata  arb -> host  read data, valid from cpu_ack until next access
//   cpu_ready  arb -> host  IOCHRDY, low while an access is outstanding
//
// Modports: master = host side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface vram_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        cpu_ready;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata, cpu_ready
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata, cpu_ready
   );
endinterface

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter -- shares one synchronous byte-wide VRAM between the CRTC
// character/attribute fetch and host CPU accesses.
//
// Parameters
//   FETCH_ATTR   1: fetch char + attribute byte per character, 0: char only
//   CPU_IN_DISP  1: CPU may be served during active display,
//                0: CPU only served while display_enable is low
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   divclk            one-clk character strobe (same strobe as the CRTC)
//   mem_addr          CRTC character address, sampled on divclk
//   display_enable    CRTC active-display flag
//   cpu               vram_if.slave CPU bus (req/we/addr/wdata, ack/rdata/ready)
//   ram_addr/we/din   RAM address, write enable, write data (combinational
//                     from the current state; all zero in IDLE)
//   ram_dout          RAM read data, one clk after the address
//   char_byte         last fetched character byte
//   attr_byte         last fetched attribute byte
//   fetch_valid       one-clk pulse when char/attr bytes are updated
//   overrun           sticky: a character strobe arrived while the previous
//                     one was still waiting for the RAM
//
// A display fetch always takes priority over the CPU. A strobe that arrives
// while the RAM is busy is parked in fetch_pend and started as soon as the
// current fetch or CPU access finishes.
// -----------------------------------------------------------------------------
module vram_arbiter #(
   parameter bit FETCH_ATTR  = 1'b1,
   parameter bit CPU_IN_DISP = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        divclk,
   input  logic [13:0] mem_addr,
   input  logic        display_enable,
   vram_if.slave       cpu,
   output logic [13:0] ram_addr,
   output logic        ram_we,
   output logic [7:0]  ram_din,
   input  logic [7:0]  ram_dout,
   output logic [7:0]  char_byte,
   output logic [7:0]  attr_byte,
   output logic        fetch_valid,
   output logic        overrun
);

   typedef enum logic [2:0] {
      IDLE,
      F_CHAR,
      F_ATTR,
      F_LAST,
      CPU_ACC,
      CPU_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        fetch_pend_q, fetch_pend_d;
   logic [12:0] cap_addr_q, cap_addr_d;      // most recent strobe address
   logic [12:0] fetch_addr_q, fetch_addr_d;  // address of fetch in progress
   logic        served_q, served_d;
   logic        overrun_q, overrun_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic [7:0]  char_byte_q, char_byte_d;
   logic [7:0]  attr_byte_q, attr_byte_d;

   logic        strobe;
   logic        cpu_elig;

   // Character addresses map to byte pairs, so the top CRTC address bit
   // falls off the end of the 14-bit RAM address.
   logic        unused_mem_msb;
   assign unused_mem_msb = mem_addr[13];

   // A strobe outside active display never produces a fetch.
   assign strobe   = divclk & display_enable;
   assign cpu_elig = cpu.cpu_req & ~served_q & (CPU_IN_DISP | ~display_enable);

   // ------------------------------------------------------------------------
   // Next state and registered outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      fetch_pend_d  = fetch_pend_q;
      cap_addr_d    = cap_addr_q;
      fetch_addr_d  = fetch_addr_q;
      served_d      = served_q;
      overrun_d     = overrun_q;
      cpu_ack_d     = 1'b0;
      cpu_rdata_d   = cpu_rdata_q;
      fetch_valid_d = 1'b0;
      char_byte_d   = char_byte_q;
      attr_byte_d   = attr_byte_q;

      case (state_q)
         IDLE: begin
            // Display wins a same-cycle tie with the CPU.
            if (strobe || fetch_pend_q)
               state_d = F_CHAR;
            else if (cpu_elig)
               state_d = CPU_ACC;
         end
         F_CHAR: begin
            state_d = FETCH_ATTR ? F_ATTR : F_LAST;
         end
         F_ATTR: begin
            char_byte_d = ram_dout;
            state_d     = F_LAST;
         end
         F_LAST: begin
            if (FETCH_ATTR)
               attr_byte_d = ram_dout;
            else
               char_byte_d = ram_dout;
            fetch_valid_d = 1'b1;
            if (fetch_pend_q)
               state_d = F_CHAR;
            else if (cpu_elig)
               state_d = CPU_ACC;
            else
               state_d = IDLE;
         end
         CPU_ACC: begin
            state_d = CPU_DONE;
         end
         CPU_DONE: begin
            if (!cpu.cpu_we)
               cpu_rdata_d = ram_dout;
            cpu_ack_d = 1'b1;
            state_d   = fetch_pend_q ? F_CHAR : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A strobe that lands on top of a still-pending one loses the older
      // address; flag it permanently so the host can tell the screen glitched.
      if (strobe) begin
         cap_addr_d = mem_addr[12:0];
         if (fetch_pend_q)
            overrun_d = 1'b1;
      end

      // The freshest strobe address is used when a fetch starts; the running
      // fetch keeps its own copy so a mid-fetch strobe cannot split a pair.
      if (state_d == F_CHAR) begin
         fetch_pend_d = 1'b0;
         fetch_addr_d = strobe ? mem_addr[12:0] : cap_addr_q;
      end else if (strobe) begin
         fetch_pend_d = 1'b1;
      end

      // One access per request: served stays set until the host drops req.
      served_d = cpu.cpu_req & (served_q | (state_q == CPU_DONE));
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         fetch_pend_q  <= 1'b0;
         cap_addr_q    <= '0;
         fetch_addr_q  <= '0;
         served_q      <= 1'b0;
         overrun_q     <= 1'b0;
         cpu_ack_q     <= 1'b0;
         cpu_rdata_q   <= '0;
         fetch_valid_q <= 1'b0;
         char_byte_q   <= '0;
         attr_byte_q   <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pend_q  <= fetch_pend_d;
         cap_addr_q    <= cap_addr_d;
         fetch_addr_q  <= fetch_addr_d;
         served_q      <= served_d;
         overrun_q     <= overrun_d;
         cpu_ack_q     <= cpu_ack_d;
         cpu_rdata_q   <= cpu_rdata_d;
         fetch_valid_q <= fetch_valid_d;
         char_byte_q   <= char_byte_d;
         attr_byte_q   <= attr_byte_d;
      end
   end

   // ------------------------------------------------------------------------
   // RAM port: driven purely from the current state so reset (state IDLE)
   // forces address, data and write enable to zero on the next clock.
   // ------------------------------------------------------------------------
   always_comb begin
      ram_addr = '0;
      ram_we   = 1'b0;
      ram_din  = '0;
      case (state_q)
         F_CHAR:  ram_addr = {fetch_addr_q, 1'b0};
         F_ATTR:  ram_addr = {fetch_addr_q, 1'b1};
         CPU_ACC: begin
            ram_addr = cpu.cpu_addr;
            ram_we   = cpu.cpu_we;
            ram_din  = cpu.cpu_wdata;
         end
         default: ;
      endcase
   end

   assign cpu.cpu_ack   = cpu_ack_q;
   assign cpu.cpu_rdata = cpu_rdata_q;
   // served rises on the same edge as cpu_ack, releasing IOCHRDY with it.
   assign cpu.cpu_ready = ~(cpu.cpu_req & ~served_q);

   assign char_byte   = char_byte_q;
   assign attr_byte   = attr_byte_q;
   assign fetch_valid = fetch_valid_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter -- directed stimulus with a queue-based scoreboard.
// dut  : FETCH_ATTR=1, CPU_IN_DISP=1
// dut2 : FETCH_ATTR=0, CPU_IN_DISP=0
// Each DUT has its own synchronous RAM model, preloaded during reset.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

   typedef struct { logic [7:0] c; logic [7:0] a; int cyc; } fexp_t;
   typedef struct { logic [7:0] rd; int cyc; } cexp_t;
   typedef struct { logic [13:0] addr; logic [7:0] d; int cyc; } wexp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset, divclk, display_enable;
   logic [13:0] mem_addr, ram_addr;
   logic        ram_we, fetch_valid, overrun;
   logic [7:0]  ram_din, ram_dout, char_byte, attr_byte;

   logic        divclk2, display_enable2;
   logic [13:0] mem_addr2, ram_addr2;
   logic        ram_we2, fetch_valid2, overrun2;
   logic [7:0]  ram_din2, ram_dout2, char_byte2, attr_byte2;

   vram_if bus();
   vram_if bus2();

   vram_arbiter #(.FETCH_ATTR(1'b1), .CPU_IN_DISP(1'b1)) dut (
      .clk(clk), .reset(reset), .divclk(divclk), .mem_addr(mem_addr),
      .display_enable(display_enable), .cpu(bus),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
      .char_byte(char_byte), .attr_byte(attr_byte),
      .fetch_valid(fetch_valid), .overrun(overrun)
   );

   vram_arbiter #(.FETCH_ATTR(1'b0), .CPU_IN_DISP(1'b0)) dut2 (
      .clk(clk), .reset(reset), .divclk(divclk2), .mem_addr(mem_addr2),
      .display_enable(display_enable2), .cpu(bus2),
      .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_din(ram_din2), .ram_dout(ram_dout2),
      .char_byte(char_byte2), .attr_byte(attr_byte2),
      .fetch_valid(fetch_valid2), .overrun(overrun2)
   );

   // RAM models with a bench load port
   logic        ld_en, ld_sel;
   logic [13:0] ld_addr;
   logic [7:0]  ld_data;
   logic [7:0]  mem  [0:16383];
   logic [7:0]  mem2 [0:16383];

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else if (ld_en && !ld_sel) mem[ld_addr] <= ld_data;
      ram_dout <= mem[ram_addr];
   end

   always @(posedge clk) begin
      if (ram_we2) mem2[ram_addr2] <= ram_din2;
      else if (ld_en && ld_sel) mem2[ld_addr] <= ld_data;
      ram_dout2 <= mem2[ram_addr2];
   end

   fexp_t fq[$];
   cexp_t cq[$];
   wexp_t wq[$];
   fexp_t fq2[$];
   cexp_t cq2[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
   endtask

   // ------------------------------------------------------------------------
   // Monitors
   // ------------------------------------------------------------------------
   always @(negedge clk) begin : mon1
      fexp_t fe;
      cexp_t ce;
      wexp_t wx;
      if (fetch_valid) begin
         if (fq.size() == 0) fail("fetch_unexpected");
         else begin
            fe = fq.pop_front();
            chk("fetch_char", char_byte, fe.c);
            chk("fetch_attr", attr_byte, fe.a);
            if (fe.cyc >= 0) chk("fetch_cycle", cyc, fe.cyc);
         end
      end
      if (bus.cpu_ack) begin
         if (cq.size() == 0) fail("ack_unexpected");
         else begin
            ce = cq.pop_front();
            chk("ack_cycle", cyc, ce.cyc);
            chk("ack_rdata", bus.cpu_rdata, ce.rd);
            chk("ack_ready", bus.cpu_ready, 1);
         end
      end
      if (ram_we) begin
         if (wq.size() == 0) fail("ram_we_unexpected");
         else begin
            wx = wq.pop_front();
            chk("wr_addr", ram_addr, wx.addr);
            chk("wr_data", ram_din, wx.d);
            chk("wr_cycle", cyc, wx.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon2
      fexp_t fe;
      cexp_t ce;
      if (fetch_valid2) begin
         if (fq2.size() == 0) fail("fetch2_unexpected");
         else begin
            fe = fq2.pop_front();
            chk("fetch2_char", char_byte2, fe.c);
            chk("fetch2_attr", attr_byte2, fe.a);
            chk("fetch2_cycle", cyc, fe.cyc);
         end
      end
      if (bus2.cpu_ack) begin
         if (cq2.size() == 0) fail("ack2_unexpected");
         else begin
            ce = cq2.pop_front();
            chk("ack2_cycle", cyc, ce.cyc);
            chk("ack2_rdata", bus2.cpu_rdata, ce.rd);
         end
      end
      if (ram_we2) fail("ram_we2_unexpected");
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic load(input logic sel, input logic [13:0] a, input logic [7:0] d);
      ld_sel = sel; ld_addr = a; ld_data = d; ld_en = 1'b1;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic wait_ack(input logic sel, input string nm);
      int n = 0;
      while (!(sel ? bus2.cpu_ack : bus.cpu_ack) && n < 20) begin
         tick();
         n++;
      end
      chk(nm, sel ? bus2.cpu_ack : bus.cpu_ack, 1);
      if (sel) bus2.cpu_req = 1'b0;
      else     bus.cpu_req  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      int k;
      reset = 1'b1; divclk = 1'b0; display_enable = 1'b0; mem_addr = '0;
      divclk2 = 1'b0; display_enable2 = 1'b0; mem_addr2 = '0;
      ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;

      load(1'b0, 14'h00B8, 8'h41);
      load(1'b0, 14'h00B9, 8'h07);
      load(1'b0, 14'h1234, 8'h5A);
      load(1'b0, 14'h0400, 8'h11);
      load(1'b0, 14'h0401, 8'h22);
      load(1'b0, 14'h0010, 8'h00);
      load(1'b0, 14'h0020, 8'h33);
      load(1'b0, 14'h0060, 8'h44);
      load(1'b0, 14'h0061, 8'h55);
      load(1'b0, 14'h0100, 8'h66);
      for (int i = 0; i < 5; i++) begin
         load(1'b0, 14'(14'h0600 + 2 * i), 8'(8'h80 + i));
         load(1'b0, 14'(14'h0601 + 2 * i), 8'(8'h90 + i));
      end
      load(1'b1, 14'h000A, 8'h99);
      load(1'b1, 14'h0042, 8'hC3);

      // reset state
      at_neg();
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_we_din", {ram_we, ram_din}, 0);
      chk("rst_flags", {bus.cpu_ack, fetch_valid, overrun}, 0);
      chk("rst_bytes", {bus.cpu_rdata, char_byte, attr_byte}, 0);
      chk("rst_ready", bus.cpu_ready, 1);
      tick();
      reset = 1'b0;
      idle(2);

      // display fetch: 0x5C -> bytes 0xB8/0xB9, fetch_valid 4 clks later
      tick();
      k = cyc;
      display_enable = 1'b1; mem_addr = 14'h005C; divclk = 1'b1;
      fq.push_back('{8'h41, 8'h07, k + 4});
      tick();
      divclk = 1'b0;
      at_neg();
      chk("fchar_addr", ram_addr, 14'h00B8);
      chk("fchar_we", ram_we, 0);
      tick();
      at_neg();
      chk("fattr_addr", ram_addr, 14'h00B9);
      idle(6);

      // CPU read with no strobe
      display_enable = 1'b0;
      tick();
      k = cyc;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h1234;
      cq.push_back('{8'h5A, k + 3});
      at_neg();
      chk("rd_ready_low", bus.cpu_ready, 0);
      wait_ack(1'b0, "rd_ack_seen");
      idle(3);

      // CPU write racing a strobe: fetch first, write after F_LAST;
      // a write leaves cpu_rdata at the previous read value
      tick();
      k = cyc;
      display_enable = 1'b1; mem_addr = 14'h0200; divclk = 1'b1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0010; bus.cpu_wdata = 8'hA5;
      fq.push_back('{8'h11, 8'h22, k + 4});
      wq.push_back('{14'h0010, 8'hA5, k + 4});
      cq.push_back('{8'h5A, k + 6});
      tick();
      divclk = 1'b0;
      wait_ack(1'b0, "wr_ack_seen");
      idle(3);
      tick();
      k = cyc;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0010;
      cq.push_back('{8'hA5, k + 3});
      wait_ack(1'b0, "rb_ack_seen");
      idle(3);

      // strobe during a CPU access is parked and run right after it
      tick();
      k = cyc;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0020;
      cq.push_back('{8'h33, k + 3});
      tick();
      divclk = 1'b1; mem_addr = 14'h0030;
      fq.push_back('{8'h44, 8'h55, k + 6});
      tick();
      divclk = 1'b0;
      wait_ack(1'b0, "pend_ack_seen");
      idle(6);
      at_neg();
      chk("no_overrun", overrun, 0);

      // strobes every 2 clks: address 0x302 is overwritten by 0x303
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) begin
            k = cyc;
            fq.push_back('{8'h80, 8'h90, k + 4});
            fq.push_back('{8'h81, 8'h91, k + 7});
            fq.push_back('{8'h83, 8'h93, k + 10});
            fq.push_back('{8'h84, 8'h94, k + 13});
         end
         divclk = 1'b1; mem_addr = 14'(14'h0300 + i);
         if (i == 3) begin
            at_neg();
            chk("overrun_before", overrun, 0);
         end
         tick();
         divclk = 1'b0;
         if (i == 3) begin
            at_neg();
            chk("overrun_set", overrun, 1);
         end
      end
      idle(10);
      at_neg();
      chk("overrun_sticky", overrun, 1);

      // reset while in CPU_ACC: abort, no ack, then re-served after release
      tick();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0100;
      tick();
      reset = 1'b1;
      at_neg();
      chk("acc_addr", ram_addr, 14'h0100);
      tick();
      reset = 1'b0;
      cq.push_back('{8'h66, cyc + 3});
      at_neg();
      chk("rstacc_ram_addr", ram_addr, 0);
      chk("rstacc_we_din", {ram_we, ram_din}, 0);
      chk("rstacc_flags", {bus.cpu_ack, fetch_valid, overrun}, 0);
      chk("rstacc_bytes", {bus.cpu_rdata, char_byte, attr_byte}, 0);
      wait_ack(1'b0, "rstacc_ack_seen");
      idle(3);

      // dut2: char-only fetch, 3-clk latency
      tick();
      k = cyc;
      display_enable2 = 1'b1; mem_addr2 = 14'h0005; divclk2 = 1'b1;
      fq2.push_back('{8'h99, 8'h00, k + 3});
      tick();
      divclk2 = 1'b0;
      at_neg();
      chk("f2_addr", ram_addr2, 14'h000A);
      idle(5);

      // dut2: CPU held off during active display
      tick();
      bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b0; bus2.cpu_addr = 14'h0042;
      repeat (5) begin
         tick();
         at_neg();
         chk("disp_hold_ready", bus2.cpu_ready, 0);
      end
      tick();
      k = cyc;
      display_enable2 = 1'b0;
      cq2.push_back('{8'hC3, k + 3});
      wait_ack(1'b1, "disp_ack_seen");
      idle(5);

      chk("fq_drained", fq.size(), 0);
      chk("cq_drained", cq.size(), 0);
      chk("wq_drained", wq.size(), 0);
      chk("fq2_drained", fq2.size(), 0);
      chk("cq2_drained", cq2.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter FETCH_ATTR, default 1: 1 = fetch char+attribute bytes per character, 0 = char byte only.
REQ-002 SHALL have parameter CPU_IN_DISP, default 1: 1 = CPU served during active display, 0 = CPU served only while display_enable low.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 divclk  in  1  one-clk character strobe, same strobe that advances the CRTC.
REQ-006 mem_addr  in  14  CRTC character address; display_enable  in  1  CRTC active-display flag.
REQ-007 cpu_req  in  1  level request, held with cpu_we/cpu_addr[13:0]/cpu_wdata[7:0] stable until cpu_ack.
REQ-008 cpu_ack  out  1  one-clk completion pulse; cpu_rdata  out  8  read data, valid from cpu_ack until next access.
REQ-009 cpu_ready  out  1  ISA IOCHRDY: low while access outstanding.
REQ-010 ram_addr  out  14, ram_we  out  1, ram_din  out  8, ram_dout  in  8  synchronous byte RAM, read data 1 clk after address.
REQ-011 char_byte  out  8, attr_byte  out  8, fetch_valid  out  1 (one-clk pulse), overrun  out  1 (sticky).

Function
REQ-012 States: IDLE, F_CHAR, F_ATTR, F_LAST, CPU_ACC, CPU_DONE.
REQ-013 IDLE + divclk + display_enable -> F_CHAR; divclk with display_enable low starts no fetch.
REQ-014 F_CHAR: ram_addr = {mem_addr[12:0],1'b0} (mem_addr captured at divclk), ram_we 0; -> F_ATTR if FETCH_ATTR else F_LAST.
REQ-015 F_ATTR: ram_addr = {captured[12:0],1'b1}; char_byte <= ram_dout; -> F_LAST.
REQ-016 F_LAST: attr_byte <= ram_dout (FETCH_ATTR=1) or char_byte <= ram_dout (FETCH_ATTR=0); fetch_valid registered high next cycle for exactly one clk.
REQ-017 Fetch latency: fetch_valid asserted 4 clks after divclk sample (FETCH_ATTR=1), 3 clks (FETCH_ATTR=0).
REQ-018 CPU eligible when cpu_req high, served flag clear, and (CPU_IN_DISP or ~display_enable).
REQ-019 From IDLE (no divclk same cycle) or from F_LAST: eligible CPU -> CPU_ACC, else -> IDLE.
REQ-020 CPU_ACC: ram_addr = cpu_addr, ram_we = cpu_we, ram_din = cpu_wdata; -> CPU_DONE.
REQ-021 CPU_DONE: cpu_rdata <= ram_dout (reads only; writes leave cpu_rdata unchanged), cpu_ack pulse, served set; -> IDLE.
REQ-022 served flag clears on any cycle cpu_req low; one access per request, no re-issue while cpu_req stays high.
REQ-023 cpu_ready = ~(cpu_req & ~served) combinational; high again the cycle cpu_ack asserts.
REQ-024 IDLE with divclk and eligible CPU same cycle: display wins; CPU starts after F_LAST.
REQ-025 divclk in any non-IDLE state sets fetch_pend and captures mem_addr; state leaving CPU_DONE or F_LAST goes to F_CHAR when fetch_pend set (takes priority over CPU); fetch_pend clears on entering F_CHAR.
REQ-026 divclk while fetch_pend already set: overrun <= 1, new mem_addr overwrites captured address.
REQ-027 ram_we SHALL be high only in CPU_ACC with cpu_we=1; ram_addr/ram_din 0 in IDLE.
REQ-028 Minimum divclk spacing for overrun-free CPU service: 6 clks (FETCH_ATTR=1).

Reset
REQ-029 reset: state IDLE; fetch_pend, served, overrun, cpu_ack, fetch_valid, ram_we 0; ram_addr, ram_din, char_byte, attr_byte, cpu_rdata 0.
REQ-030 reset mid-access: aborts immediately, no cpu_ack, no ram_we next cycle; held cpu_req re-served after reset release.

Verification
REQ-031 divclk, display_enable=1, mem_addr=0x005C, RAM[0xB8]=0x41, RAM[0xB9]=0x07 -> ram_addr 0xB8 then 0xB9, fetch_valid 4 clks later, char_byte=0x41, attr_byte=0x07.
REQ-032 cpu_req read addr 0x1234 (RAM=0x5A), no divclk -> cpu_ready low, cpu_ack 3 clks after req, cpu_rdata=0x5A, cpu_ready high on ack cycle.
REQ-033 cpu_req write 0x0010<-0xA5 same cycle as divclk -> fetch first, ram_we pulse at addr 0x0010 data 0xA5 after F_LAST, single cpu_ack, readback 0xA5.
REQ-034 divclk every 3 clks with CPU traffic -> fetch_pend chaining, overrun=1 stays set until reset.
REQ-035 CPU_IN_DISP=0, cpu_req during display_enable=1 -> no access until display_enable low, then cpu_ack within 3 clks.
REQ-036 reset asserted in CPU_ACC -> no cpu_ack, all outputs 0 next clk, request re-served after release.
